// File: rtl/lif_neuron_unit.sv
// Leaky integrate-and-fire neuron with per-synapse weights, pre-synaptic traces
// and a trace-driven learning rule that runs on the cycle after a fire.
//
// state   | meaning
// --------+---------------------------------------------------------------
// INTEG   | integrate masked synaptic sum minus leak, fire on threshold
// FIRE    | one-cycle spike on out_inhi, weight update on exit when learn=1
// REFRAC  | potential held at 0 for REFRAC cycles, inputs ignored
module lif_neuron_unit #(
    parameter int N_SYN     = 25,
    parameter int W_W       = 4,
    parameter int W_INIT    = 8,
    parameter int POT_W     = 10,
    parameter int THRESHOLD = 200,
    parameter int LEAK      = 1,
    parameter int REFRAC    = 5,
    parameter int TRACE_LEN = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             learn,
    input  logic [N_SYN:1]   spike_in,
    input  logic [N_SYN:1]   synapse_mask,
    input  logic             inhibition,
    output logic             out_inhi,
    output logic [POT_W-1:0] potential,
    output logic             refractory,
    input  logic [4:0]       w_rd_sel,
    output logic [W_W-1:0]   w_rd_data
);

    localparam int SUM_W = $clog2(N_SYN * ((1 << W_W) - 1) + 1);
    localparam int EXT_W = ((SUM_W > POT_W) ? SUM_W : POT_W) + 2;
    localparam int TR_W  = 3;
    localparam int CNT_W = (REFRAC > 2) ? $clog2(REFRAC) : 1;

    localparam logic [W_W-1:0]   W_MAX    = '1;
    localparam logic [W_W-1:0]   W_RST    = W_W'(W_INIT);
    localparam logic [EXT_W-1:0] POT_MAX  = EXT_W'((1 << POT_W) - 1);
    localparam logic [EXT_W-1:0] LEAK_EXT = EXT_W'(LEAK);
    localparam logic [EXT_W-1:0] THR_EXT  = EXT_W'(THRESHOLD);

    typedef enum logic [1:0] {
        ST_INTEG  = 2'd0,
        ST_FIRE   = 2'd1,
        ST_REFRAC = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [POT_W-1:0]   pot_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [W_W-1:0]     weight [1:N_SYN];
    logic [TR_W-1:0]    trace  [1:N_SYN];
    logic [SUM_W-1:0]   syn_sum;
    logic [EXT_W-1:0]   pot_raw;
    logic [EXT_W-1:0]   pot_int;
    logic               crossing;
    logic               learn_now;

    always_comb begin
        syn_sum = '0;
        for (int i = 1; i <= N_SYN; i++) begin
            if (spike_in[i] && synapse_mask[i]) begin
                syn_sum = syn_sum + SUM_W'(weight[i]);
            end
        end
    end

    // Leak is applied after adding the sum so a full-strength input still nets positive.
    always_comb begin
        pot_raw = EXT_W'(potential) + EXT_W'(syn_sum);
        if (pot_raw <= LEAK_EXT) begin
            pot_int = '0;
        end else if ((pot_raw - LEAK_EXT) > POT_MAX) begin
            pot_int = POT_MAX;
        end else begin
            pot_int = pot_raw - LEAK_EXT;
        end
        crossing = (pot_int >= THR_EXT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_INTEG;
            potential <= '0;
            cnt       <= '0;
        end else begin
            state     <= state_nxt;
            potential <= pot_nxt;
            cnt       <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pot_nxt   = potential;
        cnt_nxt   = cnt;
        case (state)
            ST_INTEG: begin
                if (inhibition) begin
                    pot_nxt = '0;
                end else if (crossing) begin
                    state_nxt = ST_FIRE;
                    pot_nxt   = '0;
                end else begin
                    pot_nxt = pot_int[POT_W-1:0];
                end
            end
            ST_FIRE: begin
                state_nxt = ST_REFRAC;
                pot_nxt   = '0;
                cnt_nxt   = CNT_W'(REFRAC - 1);
            end
            ST_REFRAC: begin
                pot_nxt = '0;
                if (cnt == '0) begin
                    state_nxt = ST_INTEG;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            default: begin
                state_nxt = ST_INTEG;
                pot_nxt   = '0;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign out_inhi   = (state == ST_FIRE);
    assign refractory = (state == ST_REFRAC);
    assign learn_now  = (state == ST_FIRE) && learn;

    // Learning reads the trace value from before this edge's reload/decay.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 1; i <= N_SYN; i++) begin
                trace[i]  <= '0;
                weight[i] <= W_RST;
            end
        end else begin
            for (int i = 1; i <= N_SYN; i++) begin
                if (spike_in[i]) begin
                    trace[i] <= TR_W'(TRACE_LEN);
                end else if (trace[i] != '0) begin
                    trace[i] <= trace[i] - TR_W'(1);
                end

                if (learn_now && synapse_mask[i]) begin
                    if (trace[i] != '0) begin
                        if (weight[i] != W_MAX) begin
                            weight[i] <= weight[i] + W_W'(1);
                        end
                    end else if (weight[i] != '0) begin
                        weight[i] <= weight[i] - W_W'(1);
                    end
                end
            end
        end
    end

    always_comb begin
        w_rd_data = '0;
        for (int i = 1; i <= N_SYN; i++) begin
            if (w_rd_sel == 5'(i)) begin
                w_rd_data = weight[i];
            end
        end
    end

endmodule

// File: tb/tb_lif_neuron_unit.sv
// Bench for lif_neuron_unit: directed scenarios with literal expectations plus a
// randomized run, all compared every cycle against an arithmetic neuron model.
module tb_lif_neuron_unit;

    logic        clk;
    logic        rst;
    logic        learn;
    logic [25:1] spike_in;
    logic [25:1] synapse_mask;
    logic        inhibition;
    logic        out_inhi;
    logic [9:0]  potential;
    logic        refractory;
    logic [4:0]  w_rd_sel;
    logic [3:0]  w_rd_data;

    int n_chk  = 0;
    int n_pass = 0;

    // model state: potential, spike pulse, refractory cycles still to serve
    int m_pot;
    int m_fire;
    int m_ref;
    int m_w  [1:25];
    int m_tr [1:25];

    lif_neuron_unit dut (
        .clk          (clk),
        .rst          (rst),
        .learn        (learn),
        .spike_in     (spike_in),
        .synapse_mask (synapse_mask),
        .inhibition   (inhibition),
        .out_inhi     (out_inhi),
        .potential    (potential),
        .refractory   (refractory),
        .w_rd_sel     (w_rd_sel),
        .w_rd_data    (w_rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_pot  = 0;
        m_fire = 0;
        m_ref  = 0;
        for (int i = 1; i <= 25; i++) begin
            m_w[i]  = 8;
            m_tr[i] = 0;
        end
    endtask

    task automatic model_step();
        int s;
        int nxt;
        s = 0;
        for (int i = 1; i <= 25; i++)
            if (spike_in[i] && synapse_mask[i]) s += m_w[i];
        if (m_fire != 0 && learn) begin
            for (int i = 1; i <= 25; i++) begin
                if (synapse_mask[i]) begin
                    if (m_tr[i] > 0) m_w[i] = (m_w[i] < 15) ? m_w[i] + 1 : 15;
                    else             m_w[i] = (m_w[i] > 0) ? m_w[i] - 1 : 0;
                end
            end
        end
        for (int i = 1; i <= 25; i++) begin
            if (spike_in[i])    m_tr[i] = 4;
            else if (m_tr[i] > 0) m_tr[i] = m_tr[i] - 1;
        end
        if (m_fire != 0) begin
            m_fire = 0;
            m_ref  = 5;
            m_pot  = 0;
        end else if (m_ref > 0) begin
            m_ref = m_ref - 1;
            m_pot = 0;
        end else if (inhibition) begin
            m_pot = 0;
        end else begin
            nxt = m_pot + s - 1;
            if (nxt < 0)    nxt = 0;
            if (nxt > 1023) nxt = 1023;
            if (nxt >= 200) begin
                m_fire = 1;
                m_pot  = 0;
            end else begin
                m_pot = nxt;
            end
        end
    endtask

    // Continuous comparison against the model, mid-cycle.
    always @(negedge clk) begin
        check("potential", int'(potential), m_pot);
        check("out_inhi", int'(out_inhi), m_fire);
        check("refractory", int'(refractory), (m_ref > 0) ? 1 : 0);
        check("w_rd_data", int'(w_rd_data),
              (w_rd_sel >= 5'd1 && w_rd_sel <= 5'd25) ? m_w[int'(w_rd_sel)] : 0);
    end

    // Called at posedge+1; returns at the next posedge+1.
    task automatic cycle();
        @(posedge clk);
        if (!rst) model_step();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic set_learn_stim();
        learn        = 1'b1;
        inhibition   = 1'b0;
        synapse_mask = '0;
        spike_in     = '0;
        for (int i = 1; i <= 10; i++) synapse_mask[i] = 1'b1;
        for (int i = 1; i <= 5; i++)  spike_in[i] = 1'b1;
    endtask

    task automatic read_weights(input string name, input int lo, input int mid, input int hi);
        learn    = 1'b0;
        spike_in = '0;
        for (int i = 1; i <= 25; i++) begin
            w_rd_sel = 5'(i);
            cycle();
            check(name, int'(w_rd_data), (i <= 5) ? lo : ((i <= 10) ? mid : hi));
        end
    endtask

    initial begin
        bit found;
        rst          = 1'b1;
        learn        = 1'b0;
        spike_in     = '0;
        synapse_mask = '0;
        inhibition   = 1'b0;
        w_rd_sel     = 5'd1;
        model_reset();
        @(posedge clk);
        #1;
        check("rst_potential", int'(potential), 0);
        check("rst_out_inhi", int'(out_inhi), 0);
        check("rst_refractory", int'(refractory), 0);
        check("rst_weight", int'(w_rd_data), 8);
        rst = 1'b0;

        // full drive: 200 per cycle less leak
        synapse_mask = '1;
        spike_in     = '1;
        cycle();
        check("full_edge1_pot", int'(potential), 199);
        cycle();
        check("full_fire", int'(out_inhi), 1);
        check("full_fire_pot", int'(potential), 0);
        for (int k = 0; k < 5; k++) begin
            cycle();
            check("refrac_len", int'(refractory), 1);
            check("refrac_out", int'(out_inhi), 0);
        end
        cycle();
        check("refrac_end", int'(refractory), 0);
        cycle();
        check("resume_pot", int'(potential), 199);
        cycle();
        check("second_fire", int'(out_inhi), 1);

        // inhibition on the crossing cycle wins
        do_reset();
        cycle();
        check("inh_edge1_pot", int'(potential), 199);
        inhibition = 1'b1;
        cycle();
        check("inh_no_fire", int'(out_inhi), 0);
        check("inh_pot", int'(potential), 0);
        inhibition = 1'b0;
        cycle();
        check("inh_after_pot", int'(potential), 199);
        cycle();
        check("inh_delayed_fire", int'(out_inhi), 1);

        // single synapse pulse decays by leak to 0
        do_reset();
        synapse_mask    = '0;
        synapse_mask[1] = 1'b1;
        spike_in        = '0;
        spike_in[1]     = 1'b1;
        cycle();
        check("pulse_pot", int'(potential), 7);
        spike_in = '0;
        for (int k = 6; k >= 0; k--) begin
            cycle();
            check("decay_pot", int'(potential), k);
        end
        cycle();
        check("decay_floor", int'(potential), 0);
        check("decay_no_fire", int'(out_inhi), 0);

        // learning: 39 per cycle, fire at edge 6
        do_reset();
        set_learn_stim();
        for (int k = 1; k <= 5; k++) begin
            cycle();
            check("learn_ramp", int'(potential), 39 * k);
        end
        cycle();
        check("learn_fire", int'(out_inhi), 1);
        cycle();
        check("learn_refrac", int'(refractory), 1);
        read_weights("learn_weight", 9, 7, 8);

        // saturation
        set_learn_stim();
        for (int k = 0; k < 200; k++) cycle();
        read_weights("sat_weight", 15, 0, 8);

        // async reset during REFRAC
        set_learn_stim();
        found = 1'b0;
        for (int k = 0; k < 60 && !found; k++) begin
            cycle();
            if (refractory) found = 1'b1;
        end
        check("wait_refrac", int'(found), 1);
        rst = 1'b1;
        model_reset();
        #1;
        check("arst_out_inhi", int'(out_inhi), 0);
        check("arst_refractory", int'(refractory), 0);
        check("arst_potential", int'(potential), 0);
        w_rd_sel = 5'd3;
        #1;
        check("arst_weight", int'(w_rd_data), 8);
        @(posedge clk);
        #1;
        rst          = 1'b0;
        learn        = 1'b0;
        synapse_mask = '1;
        spike_in     = '1;
        cycle();
        check("arst_restart_pot", int'(potential), 199);
        read_weights("arst_weight_all", 8, 8, 8);

        // randomized run
        synapse_mask = 25'($urandom());
        for (int k = 0; k < 4000; k++) begin
            learn = 1'($urandom_range(0, 1));
            if ((k / 500) % 2 == 0) spike_in = 25'($urandom() & $urandom());
            else                    spike_in = 25'($urandom() & $urandom() & $urandom() & $urandom());
            if ($urandom_range(0, 9) == 0) synapse_mask = 25'($urandom() | $urandom());
            inhibition = ($urandom_range(0, 15) == 0);
            w_rd_sel   = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 499) == 0) do_reset();
            else cycle();
        end

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
